// File: rtl/mem_arb_pkg.sv
// Shared types for the two-core data-memory arbiter: default widths,
// core identifiers and the read-return tag.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    CORE0 = 1'b0,
    CORE1 = 1'b1
  } core_id_t;

  // Marks which core owns the read data coming back from memory this cycle
  typedef struct packed {
    logic     valid;
    core_id_t core_id;
  } tag_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-request picker. Round-robin on `last` by default; with
// MEM_ARB_FIXED_PRIO_EN defined, core 0 always wins and `last` is ignored.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  core_id_t   last,
  output logic [1:0] gnt
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic last_unused;
  assign last_unused = last;

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0];
    gnt[1] = req[1] & ~req[0];
  end
`else
  always_comb begin
    gnt = req;
    // On contention the core that did not win last time goes first
    if (&req) gnt = (last == CORE1) ? 2'b01 : 2'b10;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one data-memory arbiter: combinational grant, registered memory
// command, 1-entry read-return tag. MEM_ARB_FIXED_PRIO_EN selects fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_req,
  input  logic              c1_req,
  input  logic              c0_we,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c0_gnt,
  output logic              c1_gnt,
  output logic              c0_stall,
  output logic              c1_stall,
  output logic              c0_rvalid,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] c0_rdata,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0] req, pick, gnt;
  logic       accept;
  core_id_t   last, sel, cmd_id;
  tag_t       tag;

  assign req = {c1_req, c0_req};

  arb_rr2 u_pick (
    .req  (req),
    .last (last),
    .gnt  (pick)
  );

  // Keep every output quiet while reset is held, even with requests pending
  assign gnt      = pick & {2{rst_n}};
  assign accept   = |gnt;
  assign sel      = gnt[1] ? CORE1 : CORE0;
  assign c0_gnt   = gnt[0];
  assign c1_gnt   = gnt[1];
  assign c0_stall = rst_n & c0_req & ~gnt[0];
  assign c1_stall = rst_n & c1_req & ~gnt[1];

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign last = CORE0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last <= CORE1;
    else if (accept) last <= sel;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cmd_id    <= CORE0;
      tag       <= '0;
    end else begin
      mem_en <= accept;
      if (accept) begin
        mem_we    <= (sel == CORE1) ? c1_we    : c0_we;
        mem_addr  <= (sel == CORE1) ? c1_addr  : c0_addr;
        mem_wdata <= (sel == CORE1) ? c1_wdata : c0_wdata;
        cmd_id    <= sel;
      end
      // Memory answers a read one cycle after the command, so the tag trails it
      tag <= '{valid: mem_en & ~mem_we, core_id: cmd_id};
    end
  end

  assign c0_rvalid = tag.valid & (tag.core_id == CORE0);
  assign c1_rvalid = tag.valid & (tag.core_id == CORE1);
  assign c0_rdata  = c0_rvalid ? mem_rdata : '0;
  assign c1_rdata  = c1_rvalid ? mem_rdata : '0;

endmodule
